memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 165 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between an instruction-fetch port and a load/store port.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default build gives ls fixed priority.
module memory_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_do,
    output logic              if_ack,
    input  logic              ls_en,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_di,
    output logic [DATA_W-1:0] ls_do,
    output logic              ls_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do,
    input  logic              mem_do_ack
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RESPOND  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_di_q, mem_di_d;
    logic                if_ack_q, if_ack_d;
    logic                ls_ack_q, ls_ack_d;
    logic [DATA_W-1:0]   if_do_q, if_do_d;
    logic [DATA_W-1:0]   ls_do_q, ls_do_d;
    logic                owner_ls_q, owner_ls_d;
    logic                prefer_ls;
    logic                grant_ls;
    logic                grant_if;

`ifdef ARB_ROUND_ROBIN_EN
    // Points at the port that wins the next tie: the one not granted last.
    logic                prefer_ls_q, prefer_ls_d;
    assign prefer_ls = prefer_ls_q;
`else
    assign prefer_ls = 1'b1;
`endif

    assign grant_ls = ls_en && (prefer_ls || !if_en);
    assign grant_if = if_en && !grant_ls;

    always_comb begin
        state_d    = state_q;
        mem_en_d   = mem_en_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_di_d   = mem_di_q;
        if_ack_d   = 1'b0;
        ls_ack_d   = 1'b0;
        if_do_d    = if_do_q;
        ls_do_d    = ls_do_q;
        owner_ls_d = owner_ls_q;
`ifdef ARB_ROUND_ROBIN_EN
        prefer_ls_d = prefer_ls_q;
`endif
        unique case (state_q)
            IDLE: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (grant_ls) begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = ls_we;
                    mem_addr_d = ls_addr;
                    mem_di_d   = ls_di;
                    owner_ls_d = 1'b1;
                    state_d    = MEM_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
                    prefer_ls_d = 1'b0;
`endif
                end else if (grant_if) begin
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    mem_di_d   = '0;
                    owner_ls_d = 1'b0;
                    state_d    = MEM_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
                    prefer_ls_d = 1'b1;
`endif
                end
            end
            MEM_WAIT: begin
                if (mem_do_ack) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_ls_q) begin
                        ls_do_d  = mem_do;
                        ls_ack_d = 1'b1;
                    end else begin
                        if_do_d  = mem_do;
                        if_ack_d = 1'b1;
                    end
                    state_d = RESPOND;
                end
            end
            // One dead cycle lets the released requester drop its enable before re-arbitration.
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_di_q   <= '0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            if_do_q    <= '0;
            ls_do_q    <= '0;
            owner_ls_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prefer_ls_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_di_q   <= mem_di_d;
            if_ack_q   <= if_ack_d;
            ls_ack_q   <= ls_ack_d;
            if_do_q    <= if_do_d;
            ls_do_q    <= ls_do_d;
            owner_ls_q <= owner_ls_d;
`ifdef ARB_ROUND_ROBIN_EN
            prefer_ls_q <= prefer_ls_d;
`endif
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_di   = mem_di_q;
    assign if_ack   = if_ack_q;
    assign ls_ack   = ls_ack_q;
    assign if_do    = if_do_q;
    assign ls_do    = ls_do_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: requesters push expected responses, a monitor pops on each ack.
// Memory is modelled as a ROM; grant order under contention follows the ARB_ROUND_ROBIN_EN build option.
module tb_memory_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              if_en;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_do;
    logic              if_ack;
    logic              ls_en;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_di;
    logic [DATA_W-1:0] ls_do;
    logic              ls_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_di;
    logic [DATA_W-1:0] mem_do;
    logic              mem_do_ack;

    memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .if_en(if_en), .if_addr(if_addr), .if_do(if_do), .if_ack(if_ack),
        .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr), .ls_di(ls_di),
        .ls_do(ls_do), .ls_ack(ls_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
        .mem_do(mem_do), .mem_do_ack(mem_do_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] di;
        logic [DATA_W-1:0] data;
    } exp_t;

    int                checks;
    int                failures;
    logic [DATA_W-1:0] rom [1024];
    exp_t              if_exp[$];
    exp_t              ls_exp[$];
    int                grant_log[$];
    logic              mem_auto;
    logic              mem_lat_rand;
    int                mem_lat;
    logic              manual_ack;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Memory: acks a pending request after mem_lat cycles with the ROM word at mem_addr.
    int   r_cnt;
    int   r_lat;
    logic r_manual_prev;
    initial begin
        mem_do_ack    = 1'b0;
        mem_do        = '0;
        r_cnt         = 0;
        r_lat         = 0;
        r_manual_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_do_ack) begin
                mem_do_ack = 1'b0;
                r_cnt      = 0;
            end else if (manual_ack && !r_manual_prev) begin
                mem_do_ack = 1'b1;
                mem_do     = 32'hBAD0_BAD0;
            end else if (mem_auto && mem_en) begin
                if (r_cnt == 0) r_lat = mem_lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
                if (r_cnt >= r_lat) begin
                    mem_do_ack = 1'b1;
                    mem_do     = rom[mem_addr];
                end else begin
                    r_cnt++;
                end
            end else begin
                r_cnt = 0;
            end
            r_manual_prev = manual_ack;
        end
    end

    // Monitor: records each memory transaction and scores it when the owner's ack appears.
    logic              m_prev_if, m_prev_ls, m_in_txn, m_stable, m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_di;
    exp_t              m_e;
    initial begin
        m_prev_if = 1'b0;
        m_prev_ls = 1'b0;
        m_in_txn  = 1'b0;
        m_stable  = 1'b1;
        m_we      = 1'b0;
        m_addr    = '0;
        m_di      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                m_in_txn  = 1'b0;
                m_prev_if = 1'b0;
                m_prev_ls = 1'b0;
            end else begin
                if (mem_en) begin
                    if (!m_in_txn) begin
                        m_in_txn = 1'b1;
                        m_stable = 1'b1;
                        m_addr   = mem_addr;
                        m_we     = mem_we;
                        m_di     = mem_di;
                    end else if (mem_addr !== m_addr || mem_we !== m_we || mem_di !== m_di) begin
                        m_stable = 1'b0;
                    end
                end
                if (if_ack || ls_ack) begin
                    check("ack_exclusive", 64'(if_ack & ls_ack), 64'd0);
                    check("ack_one_cycle", 64'((if_ack & m_prev_if) | (ls_ack & m_prev_ls)), 64'd0);
                    check("mem_en_low_at_ack", 64'(mem_en), 64'd0);
                end
                if (if_ack) begin
                    if (if_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL if_unexpected_ack actual=1 required=0");
                    end else begin
                        m_e = if_exp.pop_front();
                        check("if_do", 64'(if_do), 64'(m_e.data));
                        check("if_mem_addr", 64'(m_addr), 64'(m_e.addr));
                        check("if_mem_we", 64'(m_we), 64'd0);
                        check("if_mem_stable", 64'(m_stable), 64'd1);
                    end
                    grant_log.push_back(0);
                    m_in_txn = 1'b0;
                end
                if (ls_ack) begin
                    if (ls_exp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ls_unexpected_ack actual=1 required=0");
                    end else begin
                        m_e = ls_exp.pop_front();
                        check("ls_do", 64'(ls_do), 64'(m_e.data));
                        check("ls_mem_addr", 64'(m_addr), 64'(m_e.addr));
                        check("ls_mem_we", 64'(m_we), 64'(m_e.we));
                        if (m_e.we) check("ls_mem_di", 64'(m_di), 64'(m_e.di));
                        check("ls_mem_stable", 64'(m_stable), 64'd1);
                    end
                    grant_log.push_back(1);
                    m_in_txn = 1'b0;
                end
                m_prev_if = if_ack;
                m_prev_ls = ls_ack;
            end
        end
    end

    task automatic req_if(input logic [ADDR_W-1:0] a, output int waits);
        exp_t e;
        e.we = 1'b0; e.addr = a; e.di = '0; e.data = rom[a];
        @(negedge clk);
        if_exp.push_back(e);
        if_en   = 1'b1;
        if_addr = a;
        waits   = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!if_ack && waits < 60);
        checks++;
        if (!if_ack) begin
            failures++;
            $display("FAIL if_ack_timeout waited=%0d required=ack", waits);
        end
        if_en = 1'b0;
    endtask

    task automatic req_ls(input logic we, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, output int waits);
        exp_t e;
        e.we = we; e.addr = a; e.di = d; e.data = rom[a];
        @(negedge clk);
        ls_exp.push_back(e);
        ls_en   = 1'b1;
        ls_we   = we;
        ls_addr = a;
        ls_di   = d;
        waits   = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!ls_ack && waits < 60);
        checks++;
        if (!ls_ack) begin
            failures++;
            $display("FAIL ls_ack_timeout waited=%0d required=ack", waits);
        end
        ls_en = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_en"},   64'(mem_en),   64'd0);
        check({tag, "_mem_we"},   64'(mem_we),   64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_di"},   64'(mem_di),   64'd0);
        check({tag, "_if_ack"},   64'(if_ack),   64'd0);
        check({tag, "_ls_ack"},   64'(ls_ack),   64'd0);
        check({tag, "_if_do"},    64'(if_do),    64'd0);
        check({tag, "_ls_do"},    64'(ls_do),    64'd0);
    endtask

    int w0, w1, w2, w3;
    int exp_order[4];
    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        if_en = 1'b0; if_addr = '0;
        ls_en = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_di = '0;
        mem_auto = 1'b1; mem_lat_rand = 1'b0; mem_lat = 0; manual_ack = 1'b0;
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[4] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;

        // Isolated fetch, memory answers 2 cycles after mem_en.
        mem_lat = 2;
        req_if(10'h004, w0);
        check("fetch_latency", 64'(w0), 64'd4);
        check("fetch_if_do", 64'(if_do), 64'hDEAD_BEEF);

        // Isolated store.
        req_ls(1'b1, 10'h3FF, 32'h1234_5678, w0);
        check("store_latency", 64'(w0), 64'd4);

        // Minimum latency with an immediate memory ack.
        mem_lat = 0;
        req_ls(1'b0, 10'h0AA, 32'h0, w0);
        check("min_latency", 64'(w0), 64'd2);

        // Contention: two requests per port issued together and re-requested immediately.
        repeat (2) @(negedge clk);
        grant_log.delete();
        fork
            begin req_ls(1'b0, 10'h011, 32'h0, w0); req_ls(1'b1, 10'h012, 32'hCAFE_0001, w1); end
            begin req_if(10'h021, w2); req_if(10'h022, w3); end
        join
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 0, 0};
`endif
        check("contention_grants", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < grant_log.size()) check($sformatf("grant_order_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));

        // Fetch address changes while the access is in flight.
        mem_lat = 3;
        fork
            req_if(10'h010, w0);
            begin
                for (int k = 0; k < 20 && !mem_en; k++) @(negedge clk);
                @(negedge clk);
                if_addr = 10'h020;
            end
        join
        check("stability_if_do", 64'(if_do), 64'(rom[10'h010]));

        // Reset during MEM_WAIT, then a stray memory ack.
        mem_auto = 1'b0;
        @(negedge clk);
        if_en = 1'b1; if_addr = 10'h055;
        for (int k = 0; k < 20 && !mem_en; k++) @(negedge clk);
        check("abort_mem_en_seen", 64'(mem_en), 64'd1);
        @(negedge clk);
        reset = 1'b1; if_en = 1'b0;
        @(negedge clk);
        reset = 1'b0; manual_ack = 1'b1;
        check_idle_outputs("abort_reset");
        @(negedge clk);
        manual_ack = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort_after_ack");
        mem_auto = 1'b1; mem_lat = 1;
        req_if(10'h123, w0);
        check("post_reset_latency", 64'(w0), 64'd3);

        // Randomised traffic on both ports.
        mem_lat_rand = 1'b1;
        fork
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                req_if(10'($urandom_range(0, 1023)), w0);
            end
            for (int n = 0; n < 30; n++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                req_ls(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), $urandom, w1);
            end
        join
        repeat (6) @(negedge clk);
        check("if_queue_drained", 64'(if_exp.size()), 64'd0);
        check("ls_queue_drained", 64'(ls_exp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
